// File: rtl/ram_responder.sv
// Word-addressed RAM responder: one request at a time over valid/ready, a fixed
// number of wait states, then a held response carrying read data or a write echo.
module ram_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  ram_rw_flag,
  input  logic [ADDR_WIDTH-1:0] address_add_bus,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  addr_error
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rw_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    do_access;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic                    acc_rw;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a valid side holds its payload steady until that edge.
  assign req_ready = (state == S_IDLE) & rst_n;
  assign accept    = req_valid & req_ready;

  // With no wait states the access uses the request as it is being accepted.
  always_comb begin
    acc_addr  = addr_q;
    acc_rw    = rw_q;
    acc_wdata = wdata_q;
    if (state == S_IDLE) begin
      acc_addr  = address_add_bus;
      acc_rw    = ram_rw_flag;
      acc_wdata = wr_data;
    end
    if (WAIT_STATES == 0) begin
      do_access = accept;
    end else begin
      do_access = rst_n && (state == S_WAIT) && (cnt == 4'd0);
    end
    in_range = 32'(acc_addr) < 32'(DEPTH);
    idx      = acc_addr[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= address_add_bus;
      rw_q    <= ram_rw_flag;
      wdata_q <= wr_data;
    end
    if (do_access && acc_rw && in_range) begin
      mem[idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      rd_data    <= '0;
      addr_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= WS_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
      if (do_access) begin
        rd_data    <= in_range ? (acc_rw ? acc_wdata : mem[idx]) : '0;
        addr_error <= !in_range;
      end
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: one instance with two wait states, one with none,
// each transaction checked for latency, data, error flag and handshake behaviour.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        rw_flag     [2];
  logic [15:0] addr_bus    [2];
  logic [31:0] wdata       [2];
  logic        resp_valid  [2];
  logic        resp_ready  [2];
  logic [31:0] rd_data     [2];
  logic        addr_error  [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc [2];
  int prev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_responder #(.WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .ram_rw_flag(rw_flag[0]), .address_add_bus(addr_bus[0]), .wr_data(wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .rd_data(rd_data[0]), .addr_error(addr_error[0])
  );

  ram_responder #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .ram_rw_flag(rw_flag[1]), .address_add_bus(addr_bus[1]), .wr_data(wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .rd_data(rd_data[1]), .addr_error(addr_error[1])
  );

  function automatic int ws(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req_ready"},  32'(req_ready[0]),  32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid[0]), 32'd0);
    check({tag, "_rd_data"},    rd_data[0],         32'd0);
    check({tag, "_addr_error"}, 32'(addr_error[0]), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic send_req(int d, logic rw, logic [15:0] addr, logic [31:0] data);
    int guard = 0;
    rw_flag[d]   = rw;
    addr_bus[d]  = addr;
    wdata[d]     = data;
    req_valid[d] = 1'b1;
    while (!req_ready[d] && guard < 32) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 32) check("req_ready_timeout", 32'(guard), 32'd0);
    @(negedge clk);
    acc_cyc[d]   = cyc;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_resp(int d, logic [31:0] exp_data, logic exp_err, string tag);
    int lat = 1;
    while (!resp_valid[d] && lat < 32) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"},  32'(lat),            32'(ws(d) + 1));
    check({tag, "_data"}, rd_data[d],          exp_data);
    check({tag, "_err"},  32'(addr_error[d]),  32'(exp_err));
  endtask

  task automatic finish_resp(int d, string tag);
    resp_ready[d] = 1'b1;
    @(negedge clk);
    check({tag, "_resp_drop"}, 32'(resp_valid[d]), 32'd0);
    check({tag, "_rdy_back"},  32'(req_ready[d]),  32'd1);
  endtask

  task automatic txn(int d, logic rw, logic [15:0] addr, logic [31:0] data,
                     logic [31:0] exp_data, logic exp_err, string tag);
    send_req(d, rw, addr, data);
    wait_resp(d, exp_data, exp_err, tag);
    finish_resp(d, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      rw_flag[i]    = 1'b0;
      addr_bus[i]   = 16'h0;
      wdata[i]      = 32'h0;
      resp_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_ws0_req_ready", 32'(req_ready[1]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", 32'(req_ready[0]), 32'd1);

    // Write then read back, back-to-back
    txn(0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "wr10");
    prev = acc_cyc[0];
    txn(0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, "rd10");
    check("ws2_period", 32'(acc_cyc[0] - prev), 32'd4);

    // Backpressure with an ignored request pulse
    resp_ready[0] = 1'b0;
    send_req(0, 1'b0, 16'h0010, 32'h0);
    wait_resp(0, 32'hDEADBEEF, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        rw_flag[0]   = 1'b1;
        addr_bus[0]  = 16'h0010;
        wdata[0]     = 32'h55555555;
        req_valid[0] = 1'b1;
      end
      @(negedge clk);
      req_valid[0] = 1'b0;
      check("bp_valid",     32'(resp_valid[0]), 32'd1);
      check("bp_data",      rd_data[0],         32'hDEADBEEF);
      check("bp_err",       32'(addr_error[0]), 32'd0);
      check("bp_req_ready", 32'(req_ready[0]),  32'd0);
    end
    finish_resp(0, "bp");
    txn(0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, "bp_after");

    // Out-of-range accesses
    txn(0, 1'b1, 16'h00FF, 32'hCAFE00FF, 32'hCAFE00FF, 1'b0, "wr_ff");
    txn(0, 1'b1, 16'h0000, 32'h0BADF00D, 32'h0BADF00D, 1'b0, "wr_00");
    txn(0, 1'b1, 16'h0100, 32'hFFFFFFFF, 32'h00000000, 1'b1, "wr_oor");
    txn(0, 1'b0, 16'h00FF, 32'h0, 32'hCAFE00FF, 1'b0, "rd_ff");
    txn(0, 1'b0, 16'h0100, 32'h0, 32'h00000000, 1'b1, "rd_oor");
    txn(0, 1'b0, 16'h0000, 32'h0, 32'h0BADF00D, 1'b0, "rd_00");
    txn(0, 1'b1, 16'h8010, 32'h77777777, 32'h00000000, 1'b1, "wr_hi");
    txn(0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, "rd10_after_hi");

    // Reset while the write is still waiting
    txn(0, 1'b1, 16'h0020, 32'h11111111, 32'h11111111, 1'b0, "wr20");
    send_req(0, 1'b1, 16'h0020, 32'hAAAA5555);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset_a");
    @(negedge clk);
    check_reset_outputs("mid_reset_b");
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, 1'b0, 16'h0020, 32'h0, 32'h11111111, 1'b0, "rd20");

    // New request raised while the response is being taken
    send_req(0, 1'b0, 16'h0010, 32'h0);
    wait_resp(0, 32'hDEADBEEF, 1'b0, "sim1");
    rw_flag[0]   = 1'b0;
    addr_bus[0]  = 16'h0020;
    req_valid[0] = 1'b1;
    check("sim_no_ready_in_resp", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    check("sim_resp_drop",   32'(resp_valid[0]), 32'd0);
    check("sim_not_accepted", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("sim_accepted", 32'(req_ready[0]), 32'd0);
    wait_resp(0, 32'h11111111, 1'b0, "sim2");
    finish_resp(0, "sim2");

    // Zero-wait-state instance
    txn(1, 1'b1, 16'h0003, 32'h12345678, 32'h12345678, 1'b0, "ws0_wr3");
    prev = acc_cyc[1];
    txn(1, 1'b0, 16'h0003, 32'h0, 32'h12345678, 1'b0, "ws0_rd3");
    check("ws0_period_a", 32'(acc_cyc[1] - prev), 32'd2);
    prev = acc_cyc[1];
    txn(1, 1'b0, 16'h0100, 32'h0, 32'h00000000, 1'b1, "ws0_oor");
    check("ws0_period_b", 32'(acc_cyc[1] - prev), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
